prim_generic_clock_div: RTL



---
 rtl/prim_generic_clock_div.sv | 105 ++++++++++
 1 files changed

// File: rtl/prim_generic_clock_div.sv
// Programmable divide-by-N clock generator with a 4-phase divisor-change handshake
// and a scan-mode bypass of the divided output.
module prim_generic_clock_div #(
  parameter int unsigned DivWidth    = 8,
  parameter int unsigned ResetDiv    = 2,
  parameter bit          HasScanMode = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                scanmode_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                div_req_i,
  output logic                div_ack_o,
  output logic                clk_o,
  output logic                tick_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPend = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  localparam logic [DivWidth-1:0] DivOne = DivWidth'(1);
  localparam logic [DivWidth-1:0] DivRst = DivWidth'(ResetDiv);
  localparam logic                ClkRst = (ResetDiv >= 2);

  logic [1:0]          state_q, state_d;
  logic [DivWidth-1:0] div_q, div_d;
  logic [DivWidth-1:0] pend_q, pend_d;
  logic [DivWidth-1:0] cnt_q, cnt_d;
  logic                clk_q, clk_d;
  logic                tick_q, tick_d;
  logic                ack_q, ack_d;

  logic pass;
  logic boundary;
  logic bypass;

  // Divisors 0 and 1 both mean pass-through; every cycle is then a boundary.
  assign pass     = (div_q <= DivOne);
  assign boundary = pass || (cnt_q == (div_q - DivOne));

  // Counter, handshake FSM and registered output decodes.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pend_d  = pend_q;
    cnt_d   = boundary ? '0 : (cnt_q + DivOne);

    case (state_q)
      StIdle: begin
        if (div_req_i) begin
          pend_d  = div_i;
          state_d = StPend;
        end
      end
      StPend: begin
        // Applying only at a boundary makes the new period start high at cnt 0.
        if (boundary) begin
          div_d   = pend_q;
          cnt_d   = '0;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!div_req_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    clk_d  = (div_d > DivOne) && (cnt_d < (div_d >> 1));
    tick_d = (div_d <= DivOne) || (cnt_d == (div_d - DivOne));
    ack_d  = (state_d == StAck);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      div_q   <= DivRst;
      pend_q  <= DivRst;
      cnt_q   <= '0;
      clk_q   <= ClkRst;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
    end
  end

  // Output clock select; the only combinational path to an output.
  assign bypass    = (HasScanMode && scanmode_i) || pass;
  assign clk_o     = bypass ? clk_i : clk_q;
  assign tick_o    = tick_q;
  assign div_ack_o = ack_q;

endmodule
